// File: rtl/instr_encoder.sv
// Sequential MIPS instruction encoder: one command per handshake, written to consecutive instruction-memory words.
// Optional ORI/BNE support is compiled in with the ENC_EXT_OPS_EN macro.
module instr_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [ADDR_W-1:0] in_target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    typedef enum logic [1:0] {IDLE = 2'd0, ENC = 2'd1, WR = 2'd2} state_t;

    localparam logic [ADDR_W-1:0] PC_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_LAST  = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W+1:0] OFF_ONE   = {{(ADDR_W+1){1'b0}}, 1'b1};

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_BNE   = 6'b000101;

    state_t              state_r;
    logic [ADDR_W-1:0]   pc_r;
    logic [ADDR_W:0]     count_r;
    logic                full_r;
    logic                err_r;
    logic                we_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [31:0]         wdata_r;
    logic [3:0]          op_r;
    logic [4:0]          rs_r;
    logic [4:0]          rt_r;
    logic [4:0]          rd_r;
    logic [15:0]         imm_r;
    logic [ADDR_W-1:0]   target_r;

    logic [ADDR_W+1:0]   off_s;
    logic [31:0]         off32_s;
    logic [25:0]         tgt26_s;
    logic [32:0]         enc_s;

    // Returns {legal, word}; an illegal code yields legal=0 and a zero word.
    function automatic logic [32:0] encode(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [15:0] imm,
                                           input logic [25:0] tgt, input logic [15:0] off);
        logic [32:0] res;
        case (op)
            4'd0:    res = {1'b1, OPC_RTYPE, rs, rt, rd, 5'b00000, 6'b100000};
            4'd1:    res = {1'b1, OPC_RTYPE, rs, rt, rd, 5'b00000, 6'b100010};
            4'd2:    res = {1'b1, OPC_RTYPE, rs, rt, rd, 5'b00000, 6'b100100};
            4'd3:    res = {1'b1, OPC_RTYPE, rs, rt, rd, 5'b00000, 6'b100101};
            4'd4:    res = {1'b1, OPC_RTYPE, rs, rt, rd, 5'b00000, 6'b101010};
            4'd5:    res = {1'b1, OPC_LW, rs, rt, imm};
            4'd6:    res = {1'b1, OPC_SW, rs, rt, imm};
            4'd7:    res = {1'b1, OPC_BEQ, rs, rt, off};
            4'd8:    res = {1'b1, OPC_ADDI, rs, rt, imm};
            4'd9:    res = {1'b1, OPC_J, tgt};
`ifdef ENC_EXT_OPS_EN
            4'd10:   res = {1'b1, OPC_ORI, rs, rt, imm};
            4'd11:   res = {1'b1, OPC_BNE, rs, rt, off};
`endif
            default: res = {1'b0, 32'h0000_0000};
        endcase
        return res;
    endfunction

    // Branch offset relative to the word after the one being written, sign-extended from ADDR_W+2 bits.
    always_comb begin
        off_s   = {2'b00, target_r} - {2'b00, pc_r} - OFF_ONE;
        off32_s = {{(30-ADDR_W){off_s[ADDR_W+1]}}, off_s};
        tgt26_s = {{(26-ADDR_W){1'b0}}, target_r};
        enc_s   = encode(op_r, rs_r, rt_r, rd_r, imm_r, tgt26_s, off32_s[15:0]);
    end

    // Command capture, encode and write sequencing.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            pc_r     <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            err_r    <= 1'b0;
            we_r     <= 1'b0;
            addr_r   <= '0;
            wdata_r  <= 32'h0000_0000;
            op_r     <= 4'd0;
            rs_r     <= 5'd0;
            rt_r     <= 5'd0;
            rd_r     <= 5'd0;
            imm_r    <= 16'h0000;
            target_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    we_r <= 1'b0;
                    if (restart) begin
                        pc_r    <= '0;
                        count_r <= '0;
                        full_r  <= 1'b0;
                        err_r   <= 1'b0;
                    end else if (in_valid && !full_r) begin
                        op_r     <= in_op;
                        rs_r     <= in_rs;
                        rt_r     <= in_rt;
                        rd_r     <= in_rd;
                        imm_r    <= in_imm;
                        target_r <= in_target;
                        state_r  <= ENC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ENC: begin
                    if (enc_s[32]) begin
                        wdata_r <= enc_s[31:0];
                        addr_r  <= pc_r;
                        we_r    <= 1'b1;
                        state_r <= WR;
                    end else begin
                        err_r   <= 1'b1;
                        we_r    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                WR: begin
                    we_r    <= 1'b0;
                    pc_r    <= pc_r + PC_ONE;
                    count_r <= count_r + CNT_ONE;
                    full_r  <= (count_r == CNT_LAST);
                    state_r <= IDLE;
                end
                default: begin
                    we_r    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // A reset arriving during WR must suppress the strobe already registered for that cycle.
    assign mem_we    = we_r & ~reset;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign count     = count_r;
    assign full      = full_r;
    assign err       = err_r;
    assign in_ready  = (state_r == IDLE) & ~full_r & ~restart;

endmodule
